regfile_mp: RTL

//   Parametrised multi-port integer register file: NREAD combinational read ports, two

---
 rtl/regfile_mp.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp : parametrised multi-port integer register file.
//
//   - NREAD combinational read ports, packed into rd_addr / rd_data lanes.
//   - Two synchronous write ports; port 1 wins when both target the same entry.
//   - A sequential clear engine sweeps every entry to zero after reset and on
//     clear_req; the file reports ready only once the sweep has completed.
//   - Optional zero-cycle write-to-read forwarding, enabled by defining the
//     macro REGFILE_MP_BYPASS_EN. The default build reads the array only.
// ---------------------------------------------------------------------------
module regfile_mp #(
    parameter  int XLEN     = 32,
    parameter  int NREGS    = 32,
    parameter  int NREAD    = 2,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_req,
    output logic                  ready,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*XLEN-1:0] rd_data,
    input  logic                  we0,
    input  logic [AW-1:0]         wa0,
    input  logic [XLEN-1:0]       wd0,
    input  logic                  we1,
    input  logic [AW-1:0]         wa1,
    input  logic [XLEN-1:0]       wd1
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   clr_idx;
    logic [AW-1:0]   clr_idx_nxt;

    logic [XLEN-1:0] regs [NREGS];

    // Qualified write strobes: only RUN cycles without a clear request may
    // modify storage, and the hardwired zero entry never accepts data.
    logic            wr0_ok;
    logic            wr1_ok;

    // True when the address names the hardwired zero register.
    function automatic logic is_hard_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign ready = (state == ST_RUN);

    // State and sweep-counter register; reset drops straight back into CLEAR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_CLEAR;
            clr_idx <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of block order.
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
        end
    end

    // Next-state logic: sweep every entry once, then serve; clear_req restarts.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no
        // latch is inferred.
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        case (state)
            ST_CLEAR: begin
                clr_idx_nxt = clr_idx + AW'(1);
                if (clr_idx == AW'(NREGS - 1)) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (clear_req) begin
                    state_nxt   = ST_CLEAR;
                    clr_idx_nxt = '0;
                end
            end
            default: begin
                state_nxt   = ST_CLEAR;
                clr_idx_nxt = '0;
            end
        endcase
    end

    // Write qualification; port 0 yields to port 1 on an address collision.
    always_comb begin
        wr1_ok = (state == ST_RUN) && !clear_req && we1 && !is_hard_zero(wa1);
        wr0_ok = (state == ST_RUN) && !clear_req && we0 && !is_hard_zero(wa0)
                 && !(we1 && (wa1 == wa0));
    end

    // Storage array: the sweep owns it during CLEAR, the write ports in RUN.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset branch; it is zeroed by the clear sweep,
        // which keeps it mappable onto plain RAM/flop arrays without reset.
        if (state == ST_CLEAR) begin
            regs[clr_idx] <= '0;
        end else begin
            if (wr0_ok) begin
                regs[wa0] <= wd0;
            end
            if (wr1_ok) begin
                regs[wa1] <= wd1;
            end
        end
    end

    // Read lanes: array lookup, masked to zero during CLEAR and for the
    // hardwired zero entry, with optional same-cycle forwarding.
    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic [AW-1:0]   lane_addr;
        logic [XLEN-1:0] lane_data;

        assign lane_addr = rd_addr[p*AW +: AW];

        // One read lane; forwarding is gated by the same strobes that commit.
        always_comb begin
            lane_data = regs[lane_addr];
            if ((state != ST_RUN) || is_hard_zero(lane_addr)) begin
                lane_data = '0;
            end
`ifdef REGFILE_MP_BYPASS_EN
            else if (wr1_ok && (wa1 == lane_addr)) begin
                lane_data = wd1;
            end else if (wr0_ok && (wa0 == lane_addr)) begin
                lane_data = wd0;
            end
`endif
        end

        assign rd_data[p*XLEN +: XLEN] = lane_data;
    end

endmodule
